disp_source_arbiter: RTL and testbench

Round-robin arbiter that shares one dispatch data driver between `NumSources` independent requesters. Each requester has a command channel (length + valid/ready) and a data channel (data + valid/ready). The block grants one requester at a time and forwards its command downstream. It then routes that requester's data beats until the granted length has been transferred, and only then re-arbitrates. It sits between the per-channel dispatch engines and the single data driver feeding the shared external data port.

---
 rtl/disp_arb_pkg.sv | 26 ++
 rtl/disp_rr_picker.sv | 37 +++
 rtl/disp_source_arbiter.sv | 145 ++++++++++++++
 tb/tb_disp_source_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/disp_arb_pkg.sv
// Shared definitions for the dispatch source arbiter: FSM state encoding
// and the default parameter values used by the arbiter and its picker.
package disp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_STREAM = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_SOURCES  = 4;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_LENGTH_WIDTH = 16;

    // Wrapping increment of a source index, used to advance the priority pointer.
    function automatic logic [7:0] wrap_inc(input logic [7:0] idx, input logic [7:0] num);
        logic [7:0] nxt;
        if (idx >= (num - 8'd1)) begin
            nxt = 8'd0;
        end else begin
            nxt = idx + 8'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/disp_rr_picker.sv
// Combinational round-robin picker: returns the first set request bit at or
// after the pointer, wrapping around, plus a flag telling whether any was set.
module disp_rr_picker
    import disp_arb_pkg::*;
#(
    parameter int N        = DEF_NUM_SOURCES,
    parameter int IdxWidth = $clog2(N)
) (
    input  logic [N-1:0]        req,
    input  logic [IdxWidth-1:0] ptr,
    output logic                found,
    output logic [IdxWidth-1:0] idx
);

    logic [IdxWidth:0] sum;
    logic [IdxWidth:0] wrapped;

    // Scan offsets from farthest to nearest so the nearest match wins.
    always_comb begin
        found   = 1'b0;
        idx     = '0;
        sum     = '0;
        wrapped = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum     = {1'b0, ptr} + (IdxWidth + 1)'(i);
            wrapped = (sum >= (IdxWidth + 1)'(N)) ? (sum - (IdxWidth + 1)'(N)) : sum;
            if (req[wrapped[IdxWidth-1:0]]) begin
                found = 1'b1;
                idx   = wrapped[IdxWidth-1:0];
            end else begin
                found = found;
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/disp_source_arbiter.sv
// Round-robin arbiter sharing one dispatch data driver between several
// requesters: grants one source, forwards its command, then streams its beats.
module disp_source_arbiter
    import disp_arb_pkg::*;
#(
    parameter int NumSources  = DEF_NUM_SOURCES,
    parameter int DataWidth   = DEF_DATA_WIDTH,
    parameter int LengthWidth = DEF_LENGTH_WIDTH
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic [NumSources*LengthWidth-1:0] S_SRCLEN,
    input  logic [NumSources-1:0]             S_SRCVALID,
    output logic [NumSources-1:0]             S_SRCREADY,
    input  logic [NumSources*DataWidth-1:0]   S_DATA,
    input  logic [NumSources-1:0]             S_DVALID,
    output logic [NumSources-1:0]             S_DREADY,
    output logic [LengthWidth-1:0]            M_SRCLEN,
    output logic                              M_SRCVALID,
    input  logic                              M_SRCREADY,
    output logic [DataWidth-1:0]              M_DATA,
    output logic                              M_DVALID,
    input  logic                              M_DREADY,
    output logic [NumSources-1:0]             GRANT,
    output logic                              BUSY
);

    localparam int IW = $clog2(NumSources);

    arb_state_e           state_r;
    logic [IW-1:0]        ptr_r;
    logic [IW-1:0]        grant_idx_r;
    logic [LengthWidth-1:0] length_r;
    logic [LengthWidth-1:0] count_r;

    logic                 pick_found_s;
    logic [IW-1:0]        pick_idx_s;
    logic [IW-1:0]        next_ptr_s;
    logic                 beat_s;
    logic                 last_beat_s;

    logic [LengthWidth-1:0] src_len_s  [NumSources];
    logic [DataWidth-1:0]   src_data_s [NumSources];

    for (genvar i = 0; i < NumSources; i++) begin : g_unpack
        assign src_len_s[i]  = S_SRCLEN[i*LengthWidth +: LengthWidth];
        assign src_data_s[i] = S_DATA[i*DataWidth +: DataWidth];
    end

    disp_rr_picker #(
        .N        (NumSources),
        .IdxWidth (IW)
    ) u_picker (
        .req   (S_SRCVALID),
        .ptr   (ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    assign next_ptr_s  = IW'(wrap_inc(8'(grant_idx_r), 8'(NumSources)));
    assign beat_s      = M_DVALID && M_DREADY;
    assign last_beat_s = (count_r == (length_r - {{(LengthWidth-1){1'b0}}, 1'b1}));

    // Arbitration FSM with the grant, length, count and priority pointer registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            grant_idx_r <= '0;
            length_r    <= '0;
            count_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        grant_idx_r <= pick_idx_s;
                        length_r    <= src_len_s[pick_idx_s];
                        state_r     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A zero-length command is consumed here and never reaches the driver.
                    if (length_r == '0) begin
                        ptr_r   <= next_ptr_s;
                        state_r <= ST_IDLE;
                    end else if (M_SRCREADY) begin
                        count_r <= '0;
                        state_r <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (beat_s) begin
                        count_r <= count_r + {{(LengthWidth-1){1'b0}}, 1'b1};
                        if (last_beat_s) begin
                            ptr_r   <= next_ptr_s;
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Grant-indexed steering of command and data handshakes.
    always_comb begin
        S_SRCREADY = '0;
        S_DREADY   = '0;
        M_SRCVALID = 1'b0;
        M_SRCLEN   = '0;
        M_DATA     = '0;
        M_DVALID   = 1'b0;
        GRANT      = '0;
        BUSY       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                BUSY = 1'b0;
            end
            ST_ISSUE: begin
                BUSY               = 1'b1;
                GRANT[grant_idx_r] = 1'b1;
                if (length_r != '0) begin
                    M_SRCVALID              = 1'b1;
                    M_SRCLEN                = length_r;
                    S_SRCREADY[grant_idx_r] = M_SRCREADY;
                end else begin
                    S_SRCREADY[grant_idx_r] = 1'b1;
                end
            end
            ST_STREAM: begin
                BUSY                  = 1'b1;
                GRANT[grant_idx_r]    = 1'b1;
                M_DATA                = src_data_s[grant_idx_r];
                M_DVALID              = S_DVALID[grant_idx_r];
                S_DREADY[grant_idx_r] = M_DREADY;
            end
            default: begin
                BUSY = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_disp_source_arbiter.sv
// Directed self-checking bench for disp_source_arbiter (4 sources, 32-bit data,
// 16-bit lengths).
module tb_disp_source_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int LW = 16;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic [NS*LW-1:0] S_SRCLEN = '0;
    logic [NS-1:0]    S_SRCVALID = '0;
    logic [NS-1:0]    S_SRCREADY;
    logic [NS*DW-1:0] S_DATA = '0;
    logic [NS-1:0]    S_DVALID = '0;
    logic [NS-1:0]    S_DREADY;
    logic [LW-1:0]    M_SRCLEN;
    logic             M_SRCVALID;
    logic             M_SRCREADY = 1'b0;
    logic [DW-1:0]    M_DATA;
    logic             M_DVALID;
    logic             M_DREADY = 1'b0;
    logic [NS-1:0]    GRANT;
    logic             BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    disp_source_arbiter #(
        .NumSources  (NS),
        .DataWidth   (DW),
        .LengthWidth (LW)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .S_SRCLEN   (S_SRCLEN),
        .S_SRCVALID (S_SRCVALID),
        .S_SRCREADY (S_SRCREADY),
        .S_DATA     (S_DATA),
        .S_DVALID   (S_DVALID),
        .S_DREADY   (S_DREADY),
        .M_SRCLEN   (M_SRCLEN),
        .M_SRCVALID (M_SRCVALID),
        .M_SRCREADY (M_SRCREADY),
        .M_DATA     (M_DATA),
        .M_DVALID   (M_DVALID),
        .M_DREADY   (M_DREADY),
        .GRANT      (GRANT),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DW-1:0] beat_val(input int src, input int b);
        return 32'hD000_0000 | (DW'(src) << 20) | DW'(b);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, 64'(GRANT), 64'h0);
        check({tag, "_busy"}, 64'(BUSY), 64'h0);
        check({tag, "_outs"}, {M_SRCVALID, M_DVALID, S_SRCREADY, S_DREADY}, 64'h0);
        check({tag, "_mlen"}, 64'(M_SRCLEN), 64'h0);
        check({tag, "_mdata"}, 64'(M_DATA), 64'h0);
    endtask

    // Precondition: in Idle, #1 after an edge, the requests already driven.
    task automatic do_xfer(input string tag, input int src, input int len);
        int bad;
        int budget;
        bad = 0;
        check({tag, "_arb_latency"}, 64'(M_SRCVALID), 64'h0);
        tick();
        check({tag, "_issue_grant"}, 64'(GRANT), 64'(4'b0001 << src));
        check({tag, "_issue_valid"}, 64'(M_SRCVALID), 64'h1);
        check({tag, "_issue_len"}, 64'(M_SRCLEN), 64'(len));
        check({tag, "_issue_ready"}, 64'(S_SRCREADY), 64'(4'b0001 << src));
        tick();
        S_SRCVALID[src] = 1'b0;
        S_DVALID[src]   = 1'b1;
        for (int b = 0; b < len; b++) begin
            S_DATA[src*DW +: DW] = beat_val(src, b);
            #1;
            if (M_DVALID !== 1'b1 || M_DATA !== beat_val(src, b) ||
                S_DREADY !== (4'b0001 << src) || GRANT !== (4'b0001 << src)) begin
                bad++;
            end
            tick();
        end
        S_DVALID[src] = 1'b0;
        budget = 0;
        check({tag, "_beats_ok"}, 64'(bad), 64'h0);
        check({tag, "_back_idle"}, 64'(BUSY), 64'h0);
        check({tag, "_grant_off"}, 64'(GRANT), 64'h0);
    endtask

    initial begin
        int hs;
        int bad;
        int nxt;
        int cyc;

        M_SRCREADY = 1'b1;
        M_DREADY   = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset_hold");
        RESET = 1'b0;
        tick();
        check_idle_outputs("reset_rel");

        // Single request: source 1, length 3 -> pointer becomes 2.
        S_SRCLEN[1*LW +: LW] = 16'd3;
        S_SRCVALID[1] = 1'b1;
        #1;
        do_xfer("single", 1, 3);

        // Zero length on source 3 (found from pointer 2) -> pointer becomes 0.
        S_SRCLEN[3*LW +: LW] = 16'd0;
        S_SRCVALID[3] = 1'b1;
        #1;
        tick();
        check("zero_srcvalid", 64'(M_SRCVALID), 64'h0);
        check("zero_srcready", 64'(S_SRCREADY), 64'h8);
        check("zero_grant", 64'(GRANT), 64'h8);
        S_SRCVALID[3] = 1'b0;
        tick();
        check("zero_done_ready", 64'(S_SRCREADY), 64'h0);
        check("zero_done_busy", 64'(BUSY), 64'h0);

        // Full contention from pointer 0: order 0,1,2,3 then 0 again.
        for (int s = 0; s < NS; s++) begin
            S_SRCLEN[s*LW +: LW] = 16'd2;
        end
        S_SRCVALID = 4'b1111;
        #1;
        do_xfer("cont0", 0, 2);
        S_SRCVALID[0] = 1'b1;
        do_xfer("cont1", 1, 2);
        do_xfer("cont2", 2, 2);
        do_xfer("cont3", 3, 2);
        do_xfer("cont0b", 0, 2);

        // Backpressure on source 0 (pointer 1 wraps to it), length 5.
        S_SRCLEN[0*LW +: LW] = 16'd5;
        S_SRCVALID[0] = 1'b1;
        #1;
        tick();
        check("bp_issue_grant", 64'(GRANT), 64'h1);
        tick();
        S_SRCVALID[0] = 1'b0;
        S_SRCVALID[2] = 1'b1;
        hs  = 0;
        bad = 0;
        nxt = 0;
        cyc = 0;
        while (BUSY && cyc < 60) begin
            M_DREADY    = (cyc % 2 == 0);
            S_DVALID[0] = (cyc % 3 != 2);
            S_DATA[0*DW +: DW] = beat_val(0, nxt);
            #1;
            if ((S_DREADY & 4'b1110) != 4'b0000) bad++;
            if (S_DREADY[0] !== M_DREADY) bad++;
            if (M_DVALID && M_DREADY) begin
                if (M_DATA !== beat_val(0, nxt)) bad++;
                hs++;
                nxt++;
            end
            tick();
            cyc++;
        end
        S_SRCVALID[2] = 1'b0;
        S_DVALID[0] = 1'b0;
        M_DREADY    = 1'b1;
        check("bp_handshakes", 64'(hs), 64'd5);
        check("bp_data_ready_ok", 64'(bad), 64'h0);
        check("bp_back_idle", 64'(BUSY), 64'h0);

        // Reset during Stream on source 2, length 4, after two beats.
        S_SRCLEN[2*LW +: LW] = 16'd4;
        S_SRCVALID[2] = 1'b1;
        #1;
        tick();
        check("rst_issue_grant", 64'(GRANT), 64'h4);
        tick();
        S_SRCVALID[2] = 1'b0;
        S_DVALID[2]   = 1'b1;
        tick();
        tick();
        check("rst_mid_stream", 64'(M_DVALID), 64'h1);
        RESET = 1'b1;
        tick();
        check_idle_outputs("rst_mid");
        RESET = 1'b0;
        S_DVALID[2] = 1'b0;
        S_SRCLEN[0*LW +: LW] = 16'd1;
        S_SRCLEN[1*LW +: LW] = 16'd1;
        S_SRCVALID = 4'b0011;
        #1;
        do_xfer("post_rst0", 0, 1);
        do_xfer("post_rst1", 1, 1);

        // Maximum length on source 2.
        S_SRCLEN[2*LW +: LW] = 16'hFFFF;
        S_SRCVALID[2] = 1'b1;
        #1;
        do_xfer("maxlen", 2, 65535);
        tick();
        check_idle_outputs("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
